instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: accepts one decoded instruction descriptor per handshake (mnemonic enum plus register/immediate/target fields) and emits the 32-bit machine word in the exact encoding our main decoder consumes. It is the producer side of the op/funct contract and sits between the test/boot program source and the instruction-memory write port. Optional pseudo-instruction expansion turns `LI` into one or two real instructions.

---
 rtl/mips_isa_pkg.sv | 125 ++++++++++++
 rtl/instr_encode_comb.sv | 61 ++++++
 rtl/instr_encoder.sv | 157 +++++++++++++++
 tb/tb_instr_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic enum, opcode/funct codes, instruction views
// and small word-building helpers used by both the encoder and the decoder side.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD   = 5'd0,
        MN_SUB   = 5'd1,
        MN_AND   = 5'd2,
        MN_OR    = 5'd3,
        MN_SLT   = 5'd4,
        MN_JR    = 5'd5,
        MN_JALR  = 5'd6,
        MN_LW    = 5'd7,
        MN_SW    = 5'd8,
        MN_BEQ   = 5'd9,
        MN_BNE   = 5'd10,
        MN_BLEZ  = 5'd11,
        MN_BGTZ  = 5'd12,
        MN_ADDI  = 5'd13,
        MN_SLTI  = 5'd14,
        MN_SLTIU = 5'd15,
        MN_ANDI  = 5'd16,
        MN_ORI   = 5'd17,
        MN_XORI  = 5'd18,
        MN_LUI   = 5'd19,
        MN_LB    = 5'd20,
        MN_LH    = 5'd21,
        MN_LBU   = 5'd22,
        MN_LHU   = 5'd23,
        MN_J     = 5'd24,
        MN_JAL   = 5'd25,
        MN_LI    = 5'd26
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } r_view_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_view_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [25:0] target;
    } j_view_t;

    typedef union packed {
        r_view_t r;
        i_view_t i;
        j_view_t j;
    } instr_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PEND_ORI = 1'b1
    } enc_state_t;

    function automatic instr_t make_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] funct);
        instr_t w;
        w.r.op    = OP_RTYPE;
        w.r.rs    = rs;
        w.r.rt    = rt;
        w.r.rd    = rd;
        w.r.shamt = 5'd0;
        w.r.funct = funct;
        return w;
    endfunction

    function automatic instr_t make_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
        instr_t w;
        w.i.op  = op;
        w.i.rs  = rs;
        w.i.rt  = rt;
        w.i.imm = imm;
        return w;
    endfunction

    function automatic instr_t make_j(input logic [5:0] op, input logic [25:0] target);
        instr_t w;
        w.j.op     = op;
        w.j.target = target;
        return w;
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Pure combinational encoder: mnemonic + fields -> machine word, legality, LI flag.
// PSEUDO_LI_EN decides whether MN_LI is reported legal.
module instr_encode_comb
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal,
    output logic        is_li
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        is_li = 1'b0;
        case (mnem)
            MN_ADD:   word = make_r(rs, rt, rd, FN_ADD);
            MN_SUB:   word = make_r(rs, rt, rd, FN_SUB);
            MN_AND:   word = make_r(rs, rt, rd, FN_AND);
            MN_OR:    word = make_r(rs, rt, rd, FN_OR);
            MN_SLT:   word = make_r(rs, rt, rd, FN_SLT);
            // Zero-required fields are forced here, whatever the caller supplied.
            MN_JR:    word = make_r(rs, 5'd0, 5'd0, FN_JR);
            MN_JALR:  word = make_r(rs, 5'd0, rd, FN_JALR);
            MN_LW:    word = make_i(OP_LW, rs, rt, imm);
            MN_SW:    word = make_i(OP_SW, rs, rt, imm);
            MN_BEQ:   word = make_i(OP_BEQ, rs, rt, imm);
            MN_BNE:   word = make_i(OP_BNE, rs, rt, imm);
            MN_BLEZ:  word = make_i(OP_BLEZ, rs, 5'd0, imm);
            MN_BGTZ:  word = make_i(OP_BGTZ, rs, 5'd0, imm);
            MN_ADDI:  word = make_i(OP_ADDI, rs, rt, imm);
            MN_SLTI:  word = make_i(OP_SLTI, rs, rt, imm);
            MN_SLTIU: word = make_i(OP_SLTIU, rs, rt, imm);
            MN_ANDI:  word = make_i(OP_ANDI, rs, rt, imm);
            MN_ORI:   word = make_i(OP_ORI, rs, rt, imm);
            MN_XORI:  word = make_i(OP_XORI, rs, rt, imm);
            MN_LUI:   word = make_i(OP_LUI, 5'd0, rt, imm);
            MN_LB:    word = make_i(OP_LB, rs, rt, imm);
            MN_LH:    word = make_i(OP_LH, rs, rt, imm);
            MN_LBU:   word = make_i(OP_LBU, rs, rt, imm);
            MN_LHU:   word = make_i(OP_LHU, rs, rt, imm);
            MN_J:     word = make_j(OP_J, target);
            MN_JAL:   word = make_j(OP_JAL, target);
            MN_LI: begin
                is_li = 1'b1;
`ifdef PSEUDO_LI_EN
                legal = 1'b1;
`else
                legal = 1'b0;
`endif
            end
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: descriptor in, registered machine word out.
// Define PSEUDO_LI_EN to expand the LI pseudo-instruction into one or two words.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_mnem,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             err,
    output logic [CNT_W-1:0] words_emitted
);

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_is_li;

    instr_encode_comb u_encode_comb (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm[15:0]),
        .target (in_target),
        .word   (enc_word),
        .legal  (enc_legal),
        .is_li  (enc_is_li)
    );

    enc_state_t       state_reg, state_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_last_reg, out_last_next;
    logic [31:0]      out_instr_reg, out_instr_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] words_reg;
    logic             accept;
    logic             take;

    assign take     = out_valid_reg & out_ready;
    assign in_ready = (state_reg == ST_IDLE) & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready;

`ifdef PSEUDO_LI_EN
    logic [4:0]  li_rt_reg, li_rt_next;
    logic [15:0] li_lo_reg, li_lo_next;
    logic        li_hi_zero;
    logic        li_hi_sext;

    assign li_hi_zero = (in_imm[31:16] == 16'h0000);
    assign li_hi_sext = &in_imm[31:15];
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:16];
`endif

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg & ~out_ready;
        out_instr_next = out_instr_reg;
        out_last_next  = out_last_reg;
        err_next       = 1'b0;
`ifdef PSEUDO_LI_EN
        li_rt_next     = li_rt_reg;
        li_lo_next     = li_lo_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (enc_legal && !enc_is_li) begin
                        out_valid_next = 1'b1;
                        out_instr_next = enc_word;
                        out_last_next  = 1'b1;
`ifdef PSEUDO_LI_EN
                    end else if (enc_legal) begin
                        out_valid_next = 1'b1;
                        out_last_next  = 1'b1;
                        if (li_hi_zero) begin
                            out_instr_next = make_i(OP_ORI, 5'd0, in_rt, in_imm[15:0]);
                        end else if (li_hi_sext) begin
                            out_instr_next = make_i(OP_ADDI, 5'd0, in_rt, in_imm[15:0]);
                        end else begin
                            out_instr_next = make_i(OP_LUI, 5'd0, in_rt, in_imm[31:16]);
                            // A zero low half needs no ORI: the LUI completes the value.
                            if (in_imm[15:0] != 16'h0000) begin
                                out_last_next = 1'b0;
                                state_next    = ST_PEND_ORI;
                                li_rt_next    = in_rt;
                                li_lo_next    = in_imm[15:0];
                            end
                        end
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
`ifdef PSEUDO_LI_EN
            ST_PEND_ORI: begin
                if (take) begin
                    out_valid_next = 1'b1;
                    out_instr_next = make_i(OP_ORI, li_rt_reg, li_rt_reg, li_lo_reg);
                    out_last_next  = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
            words_reg     <= '0;
`ifdef PSEUDO_LI_EN
            li_rt_reg     <= '0;
            li_lo_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            out_last_reg  <= out_last_next;
            err_reg       <= err_next;
            if (take && (words_reg != {CNT_W{1'b1}})) begin
                words_reg <= words_reg + 1'b1;
            end
`ifdef PSEUDO_LI_EN
            li_rt_reg     <= li_rt_next;
            li_lo_reg     <= li_lo_next;
`endif
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_instr     = out_instr_reg;
    assign out_last      = out_last_reg;
    assign err           = err_reg;
    assign words_emitted = words_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// corner sequences, and a randomized run checked by a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_encoder;
    import mips_isa_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_mnem = '0;
    logic [4:0]       in_rs = '0;
    logic [4:0]       in_rt = '0;
    logic [4:0]       in_rd = '0;
    logic [31:0]      in_imm = '0;
    logic [25:0]      in_target = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_instr;
    logic             out_last;
    logic             err;
    logic [CNT_W-1:0] words_emitted;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mnem       (in_mnem),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_imm        (in_imm),
        .in_target     (in_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_last      (out_last),
        .err           (err),
        .words_emitted (words_emitted)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (plain arithmetic on field values) ----------------
    function automatic logic [31:0] enc_r(input int unsigned rs, input int unsigned rt,
                                          input int unsigned rd, input int unsigned fn);
        return rs * 32'h0020_0000 + rt * 32'h0001_0000 + rd * 32'h0000_0800 + fn;
    endfunction

    function automatic logic [31:0] enc_i(input int unsigned op, input int unsigned rs,
                                          input int unsigned rt, input int unsigned imm16);
        return op * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000 + imm16;
    endfunction

    typedef struct {
        int          n;
        bit          illegal;
        logic [31:0] w0;
        logic        l0;
        logic [31:0] w1;
    } exp_t;

    function automatic exp_t model(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tg);
        exp_t e;
        int unsigned lo = imm % 65536;
        int unsigned hi = imm / 65536;
        e.n = 1; e.illegal = 1'b0; e.l0 = 1'b1; e.w0 = '0; e.w1 = '0;
        case (m)
            MN_ADD:   e.w0 = enc_r(rs, rt, rd, 'b100000);
            MN_SUB:   e.w0 = enc_r(rs, rt, rd, 'b100010);
            MN_AND:   e.w0 = enc_r(rs, rt, rd, 'b100100);
            MN_OR:    e.w0 = enc_r(rs, rt, rd, 'b100101);
            MN_SLT:   e.w0 = enc_r(rs, rt, rd, 'b101010);
            MN_JR:    e.w0 = enc_r(rs, 0, 0, 'b001000);
            MN_JALR:  e.w0 = enc_r(rs, 0, rd, 'b001001);
            MN_LW:    e.w0 = enc_i('b100011, rs, rt, lo);
            MN_SW:    e.w0 = enc_i('b101011, rs, rt, lo);
            MN_BEQ:   e.w0 = enc_i('b000100, rs, rt, lo);
            MN_BNE:   e.w0 = enc_i('b000101, rs, rt, lo);
            MN_BLEZ:  e.w0 = enc_i('b000110, rs, 0, lo);
            MN_BGTZ:  e.w0 = enc_i('b000111, rs, 0, lo);
            MN_ADDI:  e.w0 = enc_i('b001000, rs, rt, lo);
            MN_SLTI:  e.w0 = enc_i('b001010, rs, rt, lo);
            MN_SLTIU: e.w0 = enc_i('b001011, rs, rt, lo);
            MN_ANDI:  e.w0 = enc_i('b001100, rs, rt, lo);
            MN_ORI:   e.w0 = enc_i('b001101, rs, rt, lo);
            MN_XORI:  e.w0 = enc_i('b001110, rs, rt, lo);
            MN_LUI:   e.w0 = enc_i('b001111, 0, rt, lo);
            MN_LB:    e.w0 = enc_i('b100000, rs, rt, lo);
            MN_LH:    e.w0 = enc_i('b100001, rs, rt, lo);
            MN_LBU:   e.w0 = enc_i('b100100, rs, rt, lo);
            MN_LHU:   e.w0 = enc_i('b100101, rs, rt, lo);
            MN_J:     e.w0 = 32'h0400_0000 * 2 + tg;
            MN_JAL:   e.w0 = 32'h0400_0000 * 3 + tg;
`ifdef PSEUDO_LI_EN
            MN_LI: begin
                if (hi == 0) e.w0 = enc_i('b001101, 0, rt, lo);
                else if (imm >= 32'hFFFF_8000) e.w0 = enc_i('b001000, 0, rt, lo);
                else begin
                    e.w0 = enc_i('b001111, 0, rt, hi);
                    if (lo != 0) begin
                        e.n = 2; e.l0 = 1'b0;
                        e.w1 = enc_i('b001101, rt, rt, lo);
                    end
                end
            end
`endif
            default: begin e.n = 0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [31:0] w;
        logic        l;
    } word_t;

    word_t       q[$];
    int unsigned cnt_exp = 0;
    logic        err_exp = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            q.delete();
            err_exp = 1'b0;
            cnt_exp = 0;
        end else begin
            check("err", err, err_exp);
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
            if (out_valid && q.size() != 0) begin
                check("out_instr", out_instr, q[0].w);
                check("out_last", out_last, q[0].l);
            end
            check("words_emitted", words_emitted, (cnt_exp > 65535) ? 65535 : cnt_exp);
            err_exp = 1'b0;
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                cnt_exp++;
            end
            if (in_valid && in_ready) begin
                e = model(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
                if (e.illegal) err_exp = 1'b1;
                else begin
                    q.push_back('{e.w0, e.l0});
                    if (e.n == 2) q.push_back('{e.w1, 1'b1});
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]  m;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [25:0] tg;
        int          kind;   // 0 = dropped with err, 1 = single word, 2 = two words
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        vecs[0] = '{MN_ADDI, 5'd0,  5'd8,  5'd0,  32'd5,         26'd0,         1, 32'h2008_0005, 32'h0};
        vecs[1] = '{MN_ADD,  5'd17, 5'd18, 5'd16, 32'd0,         26'd0,         1, 32'h0232_8020, 32'h0};
        vecs[2] = '{MN_JR,   5'd31, 5'd5,  5'd7,  32'd0,         26'd0,         1, 32'h03E0_0008, 32'h0};
        vecs[3] = '{MN_J,    5'd0,  5'd0,  5'd0,  32'd0,         26'h010_0000,  1, 32'h0810_0000, 32'h0};
        vecs[4] = '{MN_BLEZ, 5'd3,  5'd9,  5'd0,  32'h10,        26'd0,         1, 32'h1860_0010, 32'h0};
`ifdef PSEUDO_LI_EN
        vecs[5] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'h1234_5678, 26'd0,         2, 32'h3C08_1234, 32'h3508_5678};
        vecs[6] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'hFFFF_FFFC, 26'd0,         1, 32'h2008_FFFC, 32'h0};
        vecs[7] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'h0001_0000, 26'd0,         1, 32'h3C08_0001, 32'h0};
`else
        vecs[5] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'h1234_5678, 26'd0,         0, 32'h0,         32'h0};
        vecs[6] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'hFFFF_FFFC, 26'd0,         0, 32'h0,         32'h0};
        vecs[7] = '{MN_LI,   5'd0,  5'd8,  5'd0,  32'h0001_0000, 26'd0,         0, 32'h0,         32'h0};
`endif
        vecs[8] = '{5'd31,   5'd1,  5'd2,  5'd3,  32'h0,         26'd0,         0, 32'h0,         32'h0};

        // reset and reset values
        repeat (3) tick;
        reset = 1'b1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words", words_emitted, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // table-driven vectors with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_mnem = vecs[i].m; in_rs = vecs[i].rs; in_rt = vecs[i].rt; in_rd = vecs[i].rd;
            in_imm = vecs[i].imm; in_target = vecs[i].tg; in_valid = 1'b1;
            check("vec_in_ready", in_ready, 1'b1);
            tick;
            in_valid = 1'b0;
            if (vecs[i].kind == 0) begin
                check("vec_err_pulse", err, 1'b1);
                check("vec_no_valid", out_valid, 1'b0);
                tick;
                check("vec_err_clear", err, 1'b0);
                check("vec_no_valid2", out_valid, 1'b0);
            end else begin
                check("vec_valid", out_valid, 1'b1);
                check("vec_word0", out_instr, vecs[i].w0);
                check("vec_last0", out_last, vecs[i].kind == 1);
                if (vecs[i].kind == 2) begin
                    check("vec_in_ready_pend", in_ready, 1'b0);
                    tick;
                    check("vec_word1", out_instr, vecs[i].w1);
                    check("vec_last1", out_last, 1'b1);
                end
                tick;
                check("vec_drained", out_valid, 1'b0);
            end
            $display("[TB] vec %0d mnem=%0d kind=%0d word0=0x%08h", i, vecs[i].m, vecs[i].kind, vecs[i].w0);
        end

        // stall: word pending with out_ready low for 5 cycles
        out_ready = 1'b0;
        in_mnem = MN_SUB; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_instr", out_instr, 32'h0022_1822);
            check("stall_in_ready", in_ready, 1'b0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        check("stall_release", out_valid, 1'b0);
        $display("[TB] stall sequence done");

        // back-to-back stream of 8 descriptors after a fresh reset
        reset = 1'b0;
        tick; tick;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_mnem = MN_ORI; in_rs = 5'(i); in_rt = 5'(i + 1); in_imm = 32'(i * 3); in_valid = 1'b1;
            check("b2b_in_ready", in_ready, 1'b1);
            tick;
        end
        in_valid = 1'b0;
        tick;
        check("b2b_words", words_emitted, 16'd8);
        $display("[TB] back-to-back stream done, words_emitted=%0d", words_emitted);

`ifdef PSEUDO_LI_EN
        // reset while ORI is pending
        out_ready = 1'b0;
        in_mnem = MN_LI; in_rt = 5'd9; in_imm = 32'hABCD_1234; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("midli_lui", out_instr, 32'h3C09_ABCD);
        check("midli_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("midli_valid", out_valid, 1'b0);
        check("midli_idle", in_ready, 1'b1);
        out_ready = 1'b1;
        tick;
        check("midli_no_ori", out_valid, 1'b0);
        $display("[TB] reset during pending ORI done");
`endif

        // randomized traffic checked by the monitor
        for (int c = 0; c < 3000; c++) begin
            int sel;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_mnem   = ($urandom % 6 == 0) ? MN_LI : 5'($urandom % 32);
            in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_target = 26'($urandom);
            sel = $urandom % 5;
            case (sel)
                0: in_imm = $urandom % 65536;
                1: in_imm = 32'hFFFF_0000 | ($urandom % 65536);
                2: in_imm = ($urandom % 65536) << 16;
                3: in_imm = 32'hFFFF_8000 - ($urandom % 4);
                default: in_imm = $urandom;
            endcase
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick;
        check("random_drain", q.size(), 0);
        $display("[TB] random phase done, words_emitted=%0d", words_emitted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
